char_vram_sequencer: RTL

CHAR_VRAM_SEQUENCER -- requirements
Module: char_vram_sequencer

---
 rtl/char_vram_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/char_vram_sequencer.sv
// Character VRAM access sequencer: CPU port with absolute priority plus a
// background engine for clear-screen, clear-row and scroll-up operations.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// FILL    | writing the fill word to addr..last, one per free port cycle
// COPY_RD | reading the source word at addr+COLS
// COPY_WR | writing the captured word to addr
// DONE    | one-cycle done/err pulse, then back to IDLE
module char_vram_sequencer #(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] cpu_a,
   input  logic [15:0] cpu_d,
   input  logic        cpu_we,
   input  logic        cpu_rd,
   output logic [15:0] cpu_q,
   output logic        cpu_rvalid,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_row,
   input  logic [15:0] cmd_fill,
   output logic        cmd_ready,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [11:0] ram_a,
   output logic [15:0] ram_d,
   output logic        ram_we,
   input  logic [15:0] ram_q
);

   localparam logic [11:0] COLS12    = 12'(COLS);
   localparam logic [11:0] LAST      = 12'(COLS * ROWS - 1);
   localparam logic [11:0] COPY_LAST = 12'(COLS * (ROWS - 1) - 1);
   localparam logic [11:0] LROW_BASE = 12'(COLS * (ROWS - 1));

   typedef enum logic [2:0] {IDLE, FILL, COPY_RD, COPY_WR, DONE} state_t;

   state_t      state;
   logic [11:0] addr;
   logic [11:0] last;
   logic [15:0] fill;
   logic [15:0] cap_word;
   logic [15:0] q_hold;
   logic        rd_pending;
   logic        cpu_gnt;
   logic        eng_we;
   logic [11:0] row_base;

   assign cpu_gnt  = cpu_we | cpu_rd;
   assign eng_we   = ((state == FILL) || (state == COPY_WR)) && !cpu_gnt;
   assign row_base = 12'(cmd_row) * COLS12;

   // The copy write may land in the very cycle the read data returns, so the
   // live ram_q is forwarded until it has been captured.
   always_comb begin
      ram_we = cpu_we | eng_we;
      ram_a  = addr;
      ram_d  = fill;
      if (cpu_gnt) begin
         ram_a = cpu_a;
         ram_d = cpu_d;
      end else if (state == COPY_RD) begin
         ram_a = addr + COLS12;
      end else if (state == COPY_WR) begin
         ram_d = rd_pending ? ram_q : cap_word;
      end
   end

   assign cpu_q = cpu_rvalid ? ram_q : q_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         cmd_ready  <= 1'b1;
         addr       <= '0;
         last       <= '0;
         fill       <= '0;
         cap_word   <= '0;
         q_hold     <= '0;
         rd_pending <= 1'b0;
         cpu_rvalid <= 1'b0;
      end else begin
         cpu_rvalid <= cpu_rd & ~cpu_we;
         if (cpu_rvalid) q_hold <= ram_q;
         rd_pending <= (state == COPY_RD) && !cpu_gnt;
         if (rd_pending) cap_word <= ram_q;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  fill      <= cmd_fill;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  err       <= 1'b0;
                  case (cmd_op)
                     2'b01: begin
                        addr  <= '0;
                        last  <= LAST;
                        state <= FILL;
                     end
                     2'b10: begin
                        addr  <= '0;
                        last  <= COPY_LAST;
                        state <= COPY_RD;
                     end
                     2'b11: begin
                        if (int'(cmd_row) < ROWS) begin
                           addr  <= row_base;
                           last  <= row_base + COLS12 - 12'd1;
                           state <= FILL;
                        end else begin
                           err   <= 1'b1;
                           done  <= 1'b1;
                           state <= DONE;
                        end
                     end
                     default: begin
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  endcase
               end
            end
            FILL: begin
               if (!cpu_gnt) begin
                  if (addr == last) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     addr <= addr + 12'd1;
                  end
               end
            end
            COPY_RD: begin
               if (!cpu_gnt) state <= COPY_WR;
            end
            COPY_WR: begin
               if (!cpu_gnt) begin
                  if (addr == last) begin
                     addr  <= LROW_BASE;
                     last  <= LAST;
                     state <= FILL;
                  end else begin
                     addr  <= addr + 12'd1;
                     state <= COPY_RD;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               err       <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
